// File: rtl/seq_tx_pkg.sv
// Shared definitions for the serial test-pattern transmitter.
package seq_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int PAT_W_DEF = 4;
  localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/pattern_shifter.sv
// Parallel-in serial-out pattern store. The index points at the bit currently on the line;
// nxt_bit/nxt_last describe the bit an advance would present, wrapping from LSB back to MSB.
module pattern_shifter #(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             advance,
  input  logic [PAT_W-1:0] pattern,
  output logic             nxt_bit,
  output logic             nxt_last,
  output logic             at_last
);

  localparam int IDX_W = $clog2(PAT_W);
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_W - 1);

  logic [PAT_W-1:0] pat_reg;
  logic [IDX_W-1:0] bit_idx;
  logic [IDX_W-1:0] nxt_idx;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pat_reg <= '0;
      bit_idx <= '0;
    end else if (load) begin
      pat_reg <= pattern;
      bit_idx <= IDX_MSB;
    end else if (advance) begin
      bit_idx <= nxt_idx;
    end
  end

  assign at_last  = (bit_idx == '0);
  assign nxt_idx  = at_last ? IDX_MSB : bit_idx - IDX_W'(1);
  assign nxt_bit  = pat_reg[nxt_idx];
  assign nxt_last = (nxt_idx == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial test-pattern transmitter: repeats a pattern MSB-first, optionally with a one-cycle gap.
// state | meaning
// IDLE  | waiting for start with non-zero repeat count
// SHIFT | a pattern bit is on data this cycle
// GAP   | idle separator cycle between repetitions (busy, no valid data)
// DONE  | one-cycle done pulse after the final bit
module seq_pattern_tx
  import seq_tx_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeats,
  input  logic             gap_en,
  input  logic             abort,
  output logic             data,
  output logic             data_valid,
  output logic             last_bit,
  output logic             busy,
  output logic             done
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] rep_cnt, rep_nxt;
  logic             gap_q, gap_nxt;
  logic             data_nxt, valid_nxt, last_nxt, busy_nxt, done_nxt;
  logic             load, advance;
  logic             sh_bit, sh_last, at_last;

  pattern_shifter #(.PAT_W(PAT_W)) u_shifter (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .advance  (advance),
    .pattern  (pattern),
    .nxt_bit  (sh_bit),
    .nxt_last (sh_last),
    .at_last  (at_last)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      rep_cnt    <= '0;
      gap_q      <= 1'b0;
      data       <= 1'b0;
      data_valid <= 1'b0;
      last_bit   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      rep_cnt    <= rep_nxt;
      gap_q      <= gap_nxt;
      data       <= data_nxt;
      data_valid <= valid_nxt;
      last_bit   <= last_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rep_nxt   = rep_cnt;
    gap_nxt   = gap_q;
    data_nxt  = 1'b0;
    valid_nxt = 1'b0;
    last_nxt  = 1'b0;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    load      = 1'b0;
    advance   = 1'b0;

    case (state)
      IDLE: begin
        if (start && (repeats != '0)) begin
          load      = 1'b1;
          rep_nxt   = repeats;
          gap_nxt   = gap_en;
          state_nxt = SHIFT;
          data_nxt  = pattern[PAT_W-1];
          valid_nxt = 1'b1;
          busy_nxt  = 1'b1;
        end
      end
      SHIFT: begin
        // rep_cnt already counts the repetition whose LSB is on the line
        if (at_last && (rep_cnt == '0)) begin
          state_nxt = DONE;
          done_nxt  = 1'b1;
        end else if (at_last && gap_q) begin
          state_nxt = GAP;
          busy_nxt  = 1'b1;
        end else begin
          advance   = 1'b1;
          data_nxt  = sh_bit;
          valid_nxt = 1'b1;
          last_nxt  = sh_last;
          busy_nxt  = 1'b1;
          if (sh_last) rep_nxt = rep_cnt - CNT_W'(1);
        end
      end
      GAP: begin
        advance   = 1'b1;
        state_nxt = SHIFT;
        data_nxt  = sh_bit;
        valid_nxt = 1'b1;
        last_nxt  = sh_last;
        busy_nxt  = 1'b1;
        if (sh_last) rep_nxt = rep_cnt - CNT_W'(1);
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (abort) begin
      state_nxt = IDLE;
      rep_nxt   = rep_cnt;
      gap_nxt   = gap_q;
      data_nxt  = 1'b0;
      valid_nxt = 1'b0;
      last_nxt  = 1'b0;
      busy_nxt  = 1'b0;
      done_nxt  = 1'b0;
      load      = 1'b0;
      advance   = 1'b0;
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx: stimulus pushes the expected output stream,
// a negedge monitor pops and compares whenever the transmitter shows activity.
module tb_seq_pattern_tx;

  localparam int PAT_W = 4;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] repeats;
  logic             gap_en;
  logic             abort;
  logic             data, data_valid, last_bit, busy, done;
  logic [4:0]       outs;

  logic [4:0] exp_q[$];
  logic [4:0] mon_exp;
  int vectors     = 0;
  int miscompares = 0;

  seq_pattern_tx #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pattern    (pattern),
    .repeats    (repeats),
    .gap_en     (gap_en),
    .abort      (abort),
    .data       (data),
    .data_valid (data_valid),
    .last_bit   (last_bit),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // outs = {busy, done, data_valid, last_bit, data}
  assign outs = {busy, done, data_valid, last_bit, data};

  task automatic check(input string nm, input logic [4:0] got, input logic [4:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got {busy,done,valid,last,data}=%b, required %b at %0t", nm, got, want, $time);
    end
  endtask

  // Reference: R copies of the pattern MSB-first, optional idle separator, then a done cycle.
  task automatic push_stream(input logic [PAT_W-1:0] p, input int r, input logic g);
    for (int k = 0; k < r; k++) begin
      for (int i = PAT_W - 1; i >= 0; i--)
        exp_q.push_back({1'b1, 1'b0, 1'b1, (i == 0), p[i]});
      if (g && (k < r - 1)) exp_q.push_back(5'b10000);
    end
    if (r > 0) exp_q.push_back(5'b01000);
  endtask

  always @(negedge clk) begin
    if (outs != 5'b0) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL stream: unexpected output %b, required no activity at %0t", outs, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        check("stream", outs, mon_exp);
      end
    end
  end

  // Holds start over two edges: from IDLE the first accepts; from DONE only the second does.
  task automatic issue(input logic [PAT_W-1:0] p, input int r, input logic g, input bit b2b);
    pattern = p;
    repeats = CNT_W'(r);
    gap_en  = g;
    start   = 1'b1;
    push_stream(p, r, g);
    @(posedge clk); #1;
    if (b2b) check("b2b_done_ignores_start", outs, 5'b0);
    else if (r > 0) check("first_bit_latency", outs, {1'b1, 1'b0, 1'b1, 1'b0, p[PAT_W-1]});
    else check("repeat0_ignored", outs, 5'b0);
    @(posedge clk); #1;
    if (b2b && r > 0) check("b2b_first_bit", outs, {1'b1, 1'b0, 1'b1, 1'b0, p[PAT_W-1]});
    start = 1'b0;
  endtask

  task automatic wait_finish(input int bound);
    int n = 0;
    while ((exp_q.size() != 0 || busy || done) && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    vectors++;
    if (n >= bound) begin
      miscompares++;
      $display("FAIL finish: timeout with %0d expected outputs pending, required 0", exp_q.size());
    end
  endtask

  task automatic wait_done_pulse(input int bound);
    int n = 0;
    while (!done && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL done_pulse: done=%b after %0d cycles, required 1", done, n);
    end
  endtask

  task automatic quiet(input int n, input string nm);
    repeat (n) begin
      @(negedge clk);
      check(nm, outs, 5'b0);
    end
  endtask

  initial begin
    logic [PAT_W-1:0] p;
    int r;
    logic g;

    rst = 1'b0; start = 1'b0; abort = 1'b0;
    pattern = '0; repeats = '0; gap_en = 1'b0;
    quiet(3, "reset_state");
    @(posedge clk); #1;
    rst = 1'b1;

    issue(4'b1010, 2, 1'b0, 1'b0);
    wait_finish(40);

    issue(4'b1010, 3, 1'b1, 1'b0);
    wait_finish(40);

    issue(4'b1111, 0, 1'b0, 1'b0);
    quiet(10, "repeat0_quiet");

    // Re-pulse start mid-stream with a different pattern: must be ignored.
    issue(4'b1100, 5, 1'b0, 1'b0);
    @(posedge clk); #1;
    pattern = 4'b0011;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    wait_finish(60);

    // Abort while the 6th bit is on the line.
    issue(4'b1010, 4, 1'b0, 1'b0);
    repeat (4) @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    exp_q.delete();
    check("abort_next_cycle", outs, 5'b0);
    quiet(4, "abort_no_done");

    // Reset while the 6th bit is on the line.
    issue(4'b1010, 4, 1'b0, 1'b0);
    repeat (4) @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    check("reset_next_cycle", outs, 5'b0);
    rst = 1'b1;
    quiet(3, "reset_no_done");

    // Back-to-back: start raised during the done cycle.
    issue(4'b1010, 2, 1'b0, 1'b0);
    wait_done_pulse(20);
    issue(4'b0110, 1, 1'b1, 1'b1);
    wait_finish(20);

    // Maximum repeat count with gaps.
    issue(4'b1001, 255, 1'b1, 1'b0);
    wait_finish(1400);

    for (int t = 0; t < 30; t++) begin
      p = PAT_W'($urandom);
      r = $urandom_range(0, 5);
      g = 1'($urandom_range(0, 1));
      issue(p, r, g, 1'b0);
      if (r == 0) begin
        quiet(2, "rand_repeat0");
      end else if ($urandom_range(0, 3) == 0) begin
        wait_done_pulse(r * (PAT_W + 1) + 10);
        issue(PAT_W'($urandom), $urandom_range(1, 3), 1'($urandom_range(0, 1)), 1'b1);
        wait_finish(40);
      end else begin
        wait_finish(r * (PAT_W + 1) + 10);
      end
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
Serial test-pattern transmitter: the driving end for the overlapping sequence detectors in the FSM sequence-detection set. It loads a PAT_W-bit pattern and shifts it out MSB-first on a one-bit serial line, once per clock, for a programmable number of repetitions. Repetitions go back-to-back, so overlapping detection is exercised, or are separated by an optional one-cycle gap. It flags the last bit of each pattern, which is the cycle in which a Mealy detector must assert its detect output.

Parameters:
PAT_W, 4, pattern length in bits (>=2)
CNT_W, 8, width of repeat counter

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-low reset, sampled on rising clk
start  input  1  request to begin transmission, sampled in IDLE only
pattern  input  PAT_W  pattern to send, MSB first, captured on accepted start
repeat  input  CNT_W  number of pattern repetitions, captured on accepted start
gap_en  input  1  1 = insert one idle cycle between repetitions, captured on accepted start
abort  input  1  synchronous stop, returns to IDLE without done
data  output  1  serial bit
data_valid  output  1  data carries a pattern bit this cycle
last_bit  output  1  data is the final (LSB) bit of a pattern instance
busy  output  1  transmission in progress
done  output  1  one-cycle pulse after the final bit of the final repetition

Behaviour:
- All outputs are registered. There is no combinational path from any input to any output.
- Reset (rst==0 at posedge):
  - state = IDLE.
  - data, data_valid, last_bit, busy and done all = 0.
  - pat_reg, bit_idx and rep_cnt all = 0.
  - Reset mid-transmission aborts with no done pulse.
- States: IDLE, SHIFT, GAP, DONE.
- IDLE:
  - If start==1 and repeat!=0 at an edge: capture pattern, repeat and gap_en; bit_idx = PAT_W-1; go to SHIFT.
  - The same edge drives data = pattern[PAT_W-1], data_valid = 1 and busy = 1. First bit latency is one cycle from start.
  - If start==1 and repeat==0: ignore, stay in IDLE, no done.
- SHIFT:
  - Each edge presents pat_reg[bit_idx] on data with data_valid = 1.
  - last_bit = 1 exactly when the presented bit index is 0.
  - After presenting index 0, rep_cnt decrements, and the next state is:
    - rep_cnt reaches 0 -> DONE.
    - else gap_en -> GAP.
    - else wrap bit_idx to PAT_W-1 and keep shifting with no bubble.
- GAP: one cycle with data = 0, data_valid = 0, last_bit = 0, busy = 1; then back to SHIFT at MSB.
- DONE: done = 1 for exactly one cycle, with busy = 0, data_valid = 0 and data = 0; then IDLE.
  - A start in the DONE cycle is ignored.
  - A start is accepted on the following IDLE edge.
- start while busy: ignored; no re-capture.
- abort == 1 in SHIFT, GAP or DONE: next edge is IDLE with all outputs 0 and no done pulse. abort has priority over start.
- rst has priority over abort and start.
- Total busy cycles for R repetitions: R*PAT_W + (R-1)*gap_en.
- rep_cnt wraps are impossible: repeat==0 is rejected and the maximum is 2^CNT_W-1.

Decomposition:
- Package seq_tx_pkg holds:
  - the state encoding constants (IDLE=2'd0, SHIFT=2'd1, GAP=2'd2, DONE=2'd3);
  - default PAT_W and CNT_W.
- One sub-module is natural: pattern_shifter, a PISO register with load, shift-enable and an index counter. It supplies the current bit and an at_last flag.
- The top level holds the FSM, the repeat counter and the output registers.

Test Plan:
- Pattern 4'b1010, repeat 2, gap_en 0 -> data 1,0,1,0,1,0,1,0 on 8 consecutive cycles starting one cycle after start. last_bit high on the 4th and 8th bits. done pulses on the 9th cycle. Fed into the overlapping 1010 Mealy detector, detect fires on both last_bit cycles.
- Pattern 4'b1010, repeat 3, gap_en 1 -> bits 1010, idle, 1010, idle, 1010 (data_valid low in the 2 idle cycles). busy high 14 cycles, then done.
- Start with repeat 0 -> no state change, busy/done/data_valid stay 0 for 10 cycles.
- Pattern 4'b1100, repeat 5, with start re-pulsed with pattern 4'b0011 on the 3rd bit -> the original 1100 stream continues unchanged for 20 bits.
- Pattern 4'b1010, repeat 4: drive abort on the 6th bit -> next cycle busy=0, data_valid=0 and no done. Repeat the run with rst=0 on the 6th bit -> all outputs 0 the next cycle.
- Back-to-back: accept start in the first IDLE cycle after done -> first bit appears one cycle later with correct MSB.
